dc_vlc_encoder: RTL and testbench

Entropy-codes the quantized DC coefficients of one slice into ProRes DC variable-length codewords. The block sits directly downstream of the slice sequencer and is driven by its `dc_vlc_reset` window and `dc_vlc_counter` index. It codes the first DC of the slice with a fixed codebook and every later DC as a sign-tracked delta with an adaptive codebook. It emits one right-aligned codeword per block, plus a running bit total and a done pulse, to the bitstream packer.

---
 rtl/dc_vlc_encoder.sv | 160 ++++++++++++++++
 tb/tb_dc_vlc_encoder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_vlc_encoder.sv
// ProRes DC coefficient VLC encoder: two-stage pipeline that codes the first DC of a
// slice with a fixed codebook and later DCs as sign-tracked deltas with an adaptive codebook.
module dc_vlc_encoder (
  input  logic               clock,
  input  logic               reset,
  input  logic               dc_vlc_reset,
  input  logic [31:0]        dc_vlc_counter,
  input  logic [31:0]        block_num,
  input  logic signed [11:0] dc_coeff,
  output logic [31:0]        vlc_code,
  output logic [5:0]         vlc_length,
  output logic               vlc_valid,
  output logic [31:0]        dc_bit_total,
  output logic               dc_vlc_done
);

  localparam logic [7:0] FIRST_CB    = 8'hB8;
  localparam logic [2:0] CB_IDX_INIT = 3'd3;

  // Two's-complement fold: 2x for x >= 0, -2x-1 for x < 0.
  function automatic logic [13:0] make_code(input logic [13:0] x);
    return {x[12:0], 1'b0} ^ {14{x[13]}};
  endfunction

  function automatic logic [7:0] dc_codebook(input logic [2:0] idx);
    case (idx)
      3'd0:       return 8'h04;
      3'd1, 3'd2: return 8'h28;
      3'd3, 3'd4: return 8'h4D;
      default:    return 8'h70;
    endcase
  endfunction

  // Stage-1 state
  logic signed [11:0] prev_dc;
  logic               sign;
  logic [2:0]         cb_idx;
  logic               s1_valid;
  logic               s1_last;
  logic [13:0]        s1_code;
  logic [7:0]         s1_cb;

  // Stage-1 combinational
  logic        accept;
  logic        is_first;
  logic        is_last;
  logic [13:0] dc_ext;
  logic [13:0] raw_delta;
  logic [13:0] adj_delta;
  logic [13:0] code_sel;
  logic [7:0]  cb_sel;
  logic [14:0] half_code;
  logic [2:0]  next_idx;

  assign accept    = dc_vlc_reset && (dc_vlc_counter < block_num);
  assign is_first  = (dc_vlc_counter == 32'd0);
  assign is_last   = (dc_vlc_counter == block_num - 32'd1);
  assign dc_ext    = {{2{dc_coeff[11]}}, dc_coeff};
  // 14 bits hold any difference of two 12-bit values, so the delta never wraps.
  assign raw_delta = dc_ext - {{2{prev_dc[11]}}, prev_dc};
  assign adj_delta = sign ? (14'd0 - raw_delta) : raw_delta;
  assign code_sel  = is_first ? make_code(dc_ext) : make_code(adj_delta);
  assign cb_sel    = is_first ? FIRST_CB : dc_codebook(cb_idx);
  assign half_code = ({1'b0, code_sel} + {14'd0, code_sel[0]}) >> 1;
  assign next_idx  = (half_code > 15'd6) ? 3'd6 : half_code[2:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_dc  <= '0;
      sign     <= 1'b0;
      cb_idx   <= CB_IDX_INIT;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_code  <= '0;
      s1_cb    <= '0;
    end else if (!dc_vlc_reset) begin
      sign     <= 1'b0;
      cb_idx   <= CB_IDX_INIT;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_code <= code_sel;
        s1_cb   <= cb_sel;
        s1_last <= is_last;
        prev_dc <= dc_coeff;
        if (is_first) begin
          sign   <= 1'b0;
          cb_idx <= CB_IDX_INIT;
        end else begin
          sign   <= raw_delta[13];
          cb_idx <= next_idx;
        end
      end
    end
  end

  // Stage-2 combinational codeword build
  logic [2:0]  rice;
  logic [2:0]  ex;
  logic [1:0]  sw;
  logic [14:0] code_w;
  logic [14:0] limit;
  logic [14:0] rice_mask;
  logic [14:0] eg_val;
  logic [3:0]  eg_msb;
  logic [31:0] code_next;
  logic [5:0]  len_next;

  assign rice   = s1_cb[7:5];
  assign ex     = s1_cb[4:2];
  assign sw     = s1_cb[1:0];
  assign code_w = {1'b0, s1_code};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    limit     = 15'({1'b0, sw} + 3'd1) << rice;
    rice_mask = (15'd1 << rice) - 15'd1;
    eg_val    = code_w - limit + (15'd1 << ex);
    eg_msb    = 4'd0;
    code_next = '0;
    len_next  = '0;
    for (int i = 0; i < 15; i++) begin
      if (eg_val[i]) eg_msb = 4'(i);
    end
    if (code_w < limit) begin
      // Quotient zeros are implicit leading zeros of the right-aligned word.
      code_next = {17'd0, (15'd1 << rice) | (code_w & rice_mask)};
      len_next  = 6'(code_w >> rice) + 6'd1 + {3'd0, rice};
    end else begin
      code_next = {17'd0, eg_val};
      len_next  = {1'b0, eg_msb, 1'b0} - {3'd0, ex} + {4'd0, sw} + 6'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vlc_code     <= '0;
      vlc_length   <= '0;
      vlc_valid    <= 1'b0;
      dc_bit_total <= '0;
      dc_vlc_done  <= 1'b0;
    end else if (!dc_vlc_reset) begin
      vlc_valid    <= 1'b0;
      dc_bit_total <= '0;
      dc_vlc_done  <= 1'b0;
    end else begin
      vlc_valid   <= s1_valid;
      dc_vlc_done <= s1_valid && s1_last;
      if (s1_valid) begin
        vlc_code     <= code_next;
        vlc_length   <= len_next;
        dc_bit_total <= dc_bit_total + {26'd0, len_next};
      end
    end
  end

endmodule

// File: tb/tb_dc_vlc_encoder.sv
// Directed testbench for dc_vlc_encoder with hand-computed codewords per scenario.
module tb_dc_vlc_encoder;

  logic               clock;
  logic               reset;
  logic               dc_vlc_reset;
  logic [31:0]        dc_vlc_counter;
  logic [31:0]        block_num;
  logic signed [11:0] dc_coeff;
  logic [31:0]        vlc_code;
  logic [5:0]         vlc_length;
  logic               vlc_valid;
  logic [31:0]        dc_bit_total;
  logic               dc_vlc_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;

  logic [31:0] q_code[$];
  logic [5:0]  q_len[$];
  logic        q_done[$];
  int          q_cyc[$];

  dc_vlc_encoder dut (
    .clock          (clock),
    .reset          (reset),
    .dc_vlc_reset   (dc_vlc_reset),
    .dc_vlc_counter (dc_vlc_counter),
    .block_num      (block_num),
    .dc_coeff       (dc_coeff),
    .vlc_code       (vlc_code),
    .vlc_length     (vlc_length),
    .vlc_valid      (vlc_valid),
    .dc_bit_total   (dc_bit_total),
    .dc_vlc_done    (dc_vlc_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (vlc_valid) begin
      q_code.push_back(vlc_code);
      q_len.push_back(vlc_length);
      q_done.push_back(dc_vlc_done);
      q_cyc.push_back(cyc);
    end
    if (dc_vlc_done) n_done++;
  endtask

  task automatic drive(input int cnt, input int dc);
    dc_vlc_counter = 32'(cnt);
    dc_coeff       = 12'(dc);
    tick();
  endtask

  task automatic clear_capture();
    q_code.delete();
    q_len.delete();
    q_done.delete();
    q_cyc.delete();
    cyc    = 0;
    n_done = 0;
  endtask

  task automatic idle();
    dc_vlc_reset   = 1'b0;
    dc_vlc_counter = '0;
    dc_coeff       = '0;
    tick();
    tick();
    clear_capture();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dc_vlc_reset = 1'b0;
    dc_vlc_counter = '0;
    block_num = '0;
    dc_coeff = '0;
    #12;
    n_checks++;
    if ({vlc_code, vlc_length, vlc_valid, dc_bit_total, dc_vlc_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: code=%h len=%0d valid=%b total=%0d done=%b, required all 0",
               vlc_code, vlc_length, vlc_valid, dc_bit_total, dc_vlc_done);
    end
    @(posedge clock);
    #3 reset = 1'b0;
    tick();
    n_checks++;
    if (vlc_valid !== 1'b0 || dc_bit_total !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_idle: valid=%b total=%0d, required 0/0", vlc_valid, dc_bit_total);
    end
    clear_capture();
  endtask

  // Slice {0,0,1,-1,-1}: exercises Rice and exp-Golomb paths plus sign tracking.
  task automatic run_basic_slice(input string tag);
    int dcs[5];
    logic [31:0] ec[5];
    logic [5:0]  el[5];
    dcs = '{0, 0, 1, -1, -1};
    ec  = '{32'h20, 32'h4, 32'h3, 32'h5, 32'h2};
    el  = '{6'd6, 6'd3, 6'd2, 6'd3, 6'd2};
    clear_capture();
    block_num = 32'd5;
    dc_vlc_reset = 1'b1;
    for (int i = 0; i < 5; i++) drive(i, dcs[i]);
    for (int i = 0; i < 3; i++) drive(5, 0);
    n_checks++;
    if (q_code.size() != 5) begin
      n_fail++;
      $display("FAIL %s_count: got %0d codewords, required 5", tag, q_code.size());
    end
    for (int i = 0; i < 5 && i < q_code.size(); i++) begin
      n_checks++;
      if (q_code[i] !== ec[i] || q_len[i] !== el[i] || q_done[i] !== (i == 4) || q_cyc[i] != i + 2) begin
        n_fail++;
        $display("FAIL %s_cw%0d: got %h/%0d done=%b cyc=%0d, required %h/%0d done=%b cyc=%0d",
                 tag, i, q_code[i], q_len[i], q_done[i], q_cyc[i], ec[i], el[i], (i == 4), i + 2);
      end
    end
    n_checks++;
    if (dc_bit_total !== 32'd16 || n_done != 1) begin
      n_fail++;
      $display("FAIL %s_total: total=%0d done_pulses=%0d, required 16/1", tag, dc_bit_total, n_done);
    end
    idle();
  endtask

  task automatic test_basic_slice();
    run_basic_slice("basic");
  endtask

  task automatic test_single_block();
    clear_capture();
    block_num = 32'd1;
    dc_vlc_reset = 1'b1;
    drive(0, -5);
    for (int i = 0; i < 3; i++) drive(1, 0);
    n_checks++;
    if (q_code.size() != 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d codewords, required 1", q_code.size());
    end else begin
      n_checks++;
      if (q_code[0] !== 32'h29 || q_len[0] !== 6'd6 || q_done[0] !== 1'b1 || q_cyc[0] != 2) begin
        n_fail++;
        $display("FAIL single_cw: got %h/%0d done=%b cyc=%0d, required 29/6 done=1 cyc=2",
                 q_code[0], q_len[0], q_done[0], q_cyc[0]);
      end
    end
    n_checks++;
    if (dc_bit_total !== 32'd6 || n_done != 1) begin
      n_fail++;
      $display("FAIL single_total: total=%0d done_pulses=%0d, required 6/1", dc_bit_total, n_done);
    end
    idle();
  endtask

  // {-2048, 2047, 2047}: large delta on codebook 0x4D, then saturated index selects 0x70.
  task automatic test_large_delta();
    int dcs[3];
    logic [31:0] ec[3];
    logic [5:0]  el[3];
    dcs = '{-2048, 2047, 2047};
    ec  = '{32'h101F, 32'h1FFE, 32'h8};
    el  = '{6'd19, 6'd23, 6'd4};
    clear_capture();
    block_num = 32'd3;
    dc_vlc_reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, dcs[i]);
    for (int i = 0; i < 3; i++) drive(3, 0);
    n_checks++;
    if (q_code.size() != 3) begin
      n_fail++;
      $display("FAIL large_count: got %0d codewords, required 3", q_code.size());
    end
    for (int i = 0; i < 3 && i < q_code.size(); i++) begin
      n_checks++;
      if (q_code[i] !== ec[i] || q_len[i] !== el[i] || q_done[i] !== (i == 2)) begin
        n_fail++;
        $display("FAIL large_cw%0d: got %h/%0d done=%b, required %h/%0d done=%b",
                 i, q_code[i], q_len[i], q_done[i], ec[i], el[i], (i == 2));
      end
    end
    n_checks++;
    if (dc_bit_total !== 32'd46) begin
      n_fail++;
      $display("FAIL large_total: total=%0d, required 46", dc_bit_total);
    end
    idle();
  endtask

  task automatic test_window_drop();
    int dcs[3];
    dcs = '{5, 40, -30};
    clear_capture();
    block_num = 32'd8;
    dc_vlc_reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, dcs[i]);
    n_checks++;
    if (dc_bit_total !== 32'd17) begin
      n_fail++;
      $display("FAIL drop_pre_total: total=%0d, required 17", dc_bit_total);
    end
    dc_vlc_reset = 1'b0;
    drive(3, 7);
    n_checks++;
    if (dc_bit_total !== 32'd0 || vlc_valid !== 1'b0 || dc_vlc_done !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_clear: total=%0d valid=%b done=%b, required 0/0/0",
               dc_bit_total, vlc_valid, dc_vlc_done);
    end
    n_checks++;
    if (vlc_code !== 32'h46 || vlc_length !== 6'd11) begin
      n_fail++;
      $display("FAIL drop_hold: code=%h len=%0d, required 46/11", vlc_code, vlc_length);
    end
    for (int i = 0; i < 3; i++) drive(4 + i, 0);
    n_checks++;
    if (q_code.size() != 2 || n_done != 0) begin
      n_fail++;
      $display("FAIL drop_pulses: got %0d codewords %0d done, required 2/0", q_code.size(), n_done);
    end else begin
      n_checks++;
      if (q_code[0] !== 32'h2A || q_len[0] !== 6'd6 || q_code[1] !== 32'h46 || q_len[1] !== 6'd11) begin
        n_fail++;
        $display("FAIL drop_cw: got %h/%0d %h/%0d, required 2a/6 46/11",
                 q_code[0], q_len[0], q_code[1], q_len[1]);
      end
    end
    // Restarted window must recode from the first-DC rule with fresh codebook state.
    clear_capture();
    block_num = 32'd2;
    dc_vlc_reset = 1'b1;
    drive(0, 0);
    drive(1, 0);
    for (int i = 0; i < 3; i++) drive(2, 0);
    n_checks++;
    if (q_code.size() != 2) begin
      n_fail++;
      $display("FAIL restart_count: got %0d codewords, required 2", q_code.size());
    end else begin
      n_checks++;
      if (q_code[0] !== 32'h20 || q_len[0] !== 6'd6 || q_code[1] !== 32'h4 || q_len[1] !== 6'd3 ||
          q_done[1] !== 1'b1 || dc_bit_total !== 32'd9) begin
        n_fail++;
        $display("FAIL restart_cw: got %h/%0d %h/%0d done=%b total=%0d, required 20/6 4/3 done=1 total=9",
                 q_code[0], q_len[0], q_code[1], q_len[1], q_done[1], dc_bit_total);
      end
    end
    idle();
  endtask

  task automatic test_counter_jump();
    int dcs[3];
    logic [31:0] ec[3];
    logic [5:0]  el[3];
    dcs = '{0, 0, 1};
    ec  = '{32'h20, 32'h4, 32'h3};
    el  = '{6'd6, 6'd3, 6'd2};
    clear_capture();
    block_num = 32'd5;
    dc_vlc_reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, dcs[i]);
    for (int i = 0; i < 4; i++) drive(9, 3);
    n_checks++;
    if (q_code.size() != 3 || n_done != 0) begin
      n_fail++;
      $display("FAIL jump_count: got %0d codewords %0d done, required 3/0", q_code.size(), n_done);
    end
    for (int i = 0; i < 3 && i < q_code.size(); i++) begin
      n_checks++;
      if (q_code[i] !== ec[i] || q_len[i] !== el[i]) begin
        n_fail++;
        $display("FAIL jump_cw%0d: got %h/%0d, required %h/%0d", i, q_code[i], q_len[i], ec[i], el[i]);
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    int dcs[3];
    dcs = '{0, 0, 1};
    clear_capture();
    block_num = 32'd5;
    dc_vlc_reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, dcs[i]);
    n_checks++;
    if (dc_bit_total !== 32'd9 || vlc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: total=%0d valid=%b, required 9/1", dc_bit_total, vlc_valid);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({vlc_code, vlc_length, vlc_valid, dc_bit_total, dc_vlc_done} !== '0) begin
      n_fail++;
      $display("FAIL areset_outputs: code=%h len=%0d valid=%b total=%0d done=%b, required all 0",
               vlc_code, vlc_length, vlc_valid, dc_bit_total, dc_vlc_done);
    end
    dc_vlc_reset = 1'b0;
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    run_basic_slice("after_reset");
  endtask

  task automatic test_block_num_zero();
    clear_capture();
    block_num = 32'd0;
    dc_vlc_reset = 1'b1;
    for (int i = 0; i < 20; i++) drive(i, i - 10);
    n_checks++;
    if (q_code.size() != 0 || n_done != 0 || dc_bit_total !== 32'd0) begin
      n_fail++;
      $display("FAIL zero_blocks: got %0d codewords %0d done total=%0d, required 0/0/0",
               q_code.size(), n_done, dc_bit_total);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_slice();
    test_single_block();
    test_large_delta();
    test_window_drop();
    test_counter_jump();
    test_async_reset();
    test_block_num_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
